// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch front end: req/ack imem read,
// instruction latch, timeout watchdog forcing HALT.
// Ports: clk, rst (async low), fetch_enable, pc_enable, pc_load,
// pc_load_value, pc, imem_req/addr/ack/rdata, instr, opcode,
// instruction_ready (pulse), fetch_error (sticky).
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_enable,
  input  logic               pc_enable,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_value,
  output logic [ADDR_W-1:0]  pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instruction_ready,
  output logic               fetch_error
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [INSTR_W-1:0] HALT =
    {4'hF, {(INSTR_W-4){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_start;
  logic                w_cap;
  logic                w_tmo;
  logic                w_wait;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req;
  logic [INSTR_W-1:0]  r_instr;
  logic                r_rdy;
  logic                r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Ack beats the watchdog when both land on the last wait cycle.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_cap   = 1'b0;
    w_tmo   = 1'b0;
    w_wait  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (fetch_enable) begin
          w_next  = S_REQ;
          w_start = 1'b1;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          w_next = S_DONE;
          w_cap  = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (pc_load)        r_pc <= pc_load_value;
      else if (pc_enable) r_pc <= r_pc + 1'b1;

      if (w_start) begin
        r_addr <= r_pc;
        r_req  <= 1'b1;
        r_cnt  <= '0;
      end else if (w_wait) begin
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_cap) begin
        r_instr <= imem_rdata;
        r_req   <= 1'b0;
      end else if (w_tmo) begin
        r_instr <= HALT;
        r_req   <= 1'b0;
      end

      r_rdy <= w_cap | w_tmo;

      // A timeout on the same edge as pc_load keeps the error set.
      if (w_tmo)        r_err <= 1'b1;
      else if (pc_load) r_err <= 1'b0;
    end
  end

  assign pc                = r_pc;
  assign imem_req          = r_req;
  assign imem_addr         = r_addr;
  assign instr             = r_instr;
  assign opcode            = r_instr[INSTR_W-1 -: 4];
  assign instruction_ready = r_rdy;
  assign fetch_error       = r_err;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Program counter plus instruction-fetch front end; sits directly upstream of the control unit.
- Holds the 8-bit PC and obeys the control unit's `pc_enable` / `pc_load` / `pc_load_value`.
- On `fetch_enable`, runs a req/ack read on instruction memory, latches the 16-bit instruction, and pulses `instruction_ready` with `opcode` valid.
- A bounded-wait watchdog turns a missing memory ack into a forced HALT instruction, so the processor cannot hang.

## Interface

Parameters:
- `ADDR_W`, 8, PC / instruction-memory address width
- `INSTR_W`, 16, instruction width; opcode is `instr[INSTR_W-1:INSTR_W-4]`
- `TIMEOUT`, 15, maximum cycles spent in REQ without ack (range 1..255)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fetch_enable`  in  1  start-fetch request from control unit
- `pc_enable`  in  1  increment PC
- `pc_load`  in  1  load PC from `pc_load_value`
- `pc_load_value`  in  ADDR_W  PC load value
- `pc`  out  ADDR_W  current program counter
- `imem_req`  out  1  memory read request (level)
- `imem_addr`  out  ADDR_W  read address; held constant while `imem_req` = 1
- `imem_ack`  in  1  memory read done; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  INSTR_W  read data
- `instr`  out  INSTR_W  latched instruction register
- `opcode`  out  4  `instr[15:12]`, combinational from `instr`
- `instruction_ready`  out  1  one-cycle pulse: `instr` / `opcode` freshly valid
- `fetch_error`  out  1  sticky: a fetch timed out

## Operation

- **Reset** (`rst` = 0, takes effect immediately, asynchronous):
  - `pc` = 0, `imem_req` = 0, `imem_addr` = 0, `instr` = 0 (so `opcode` = 0), `instruction_ready` = 0, `fetch_error` = 0
  - FSM = IDLE, timeout counter = 0
- **PC update**, every cycle, independent of the FSM:
  - `pc_load` = 1 → `pc <= pc_load_value`
  - else `pc_enable` = 1 → `pc <= pc + 1`, modulo 2^ADDR_W (0xFF wraps to 0x00)
  - `pc_load` has priority when both are high.
- **FSM states:**
  - IDLE:
    - `fetch_enable` = 1 → REQ; same edge: `imem_addr <= pc`, `imem_req <= 1`, counter cleared.
    - Otherwise stay.
  - REQ (`imem_req` = 1):
    - `imem_ack` = 1 → DONE; same edge: `instr <= imem_rdata`, `imem_req <= 0`.
    - Else, counter = TIMEOUT-1 → DONE; same edge: `instr <= {4'hF, 12'h000}` (HALT), `imem_req <= 0`, `fetch_error <= 1`.
    - Else counter increments.
  - DONE: `instruction_ready` = 1 for exactly this one cycle; → IDLE unconditionally.
- **PC changes mid-fetch:** a change to `pc` while in REQ does not affect the outstanding request; `imem_addr` stays at the value latched on entry.
- **`fetch_enable` outside IDLE:** ignored in REQ and DONE; no request is queued.
  - Re-assertion in the cycle after DONE (IDLE) starts a new fetch.
- **Ack in IDLE or DONE:** ignored; `instr` is unchanged.
- **Ack on the timeout cycle:** ack wins; the data is captured and `fetch_error` is not set.
- **`fetch_error` clearing:** only by reset or by `pc_load` = 1. Clearing is allowed in any state, except on the same edge that sets it, where set wins.
- **`instr` between fetches:** holds its value until the next capture.

## Timing

- Cycle 0: `fetch_enable` = 1 in IDLE.
- Cycle 1: `imem_req` = 1, `imem_addr` = `pc` sampled at cycle 0.
- Ack in cycle k ≥ 1 → `instruction_ready` = 1 and `instr` valid in cycle k+1.
- Minimum fetch latency: 2 cycles from `fetch_enable` to `instruction_ready` (zero-wait memory acking combinationally in cycle 1).
- Timeout: no ack in cycles 1..TIMEOUT → `instruction_ready` and `fetch_error` high in cycle TIMEOUT+1.
- Back-to-back: next `imem_req` no earlier than 2 cycles after the previous DONE cycle.
- `instruction_ready` is registered (no combinational path from `imem_ack`).

## Test plan

- **Reset:** assert `rst` = 0 mid-REQ with `pc` = 0x37 → `imem_req`, `pc`, `instr`, `instruction_ready`, `fetch_error` all 0 immediately, before the next clock edge.
- **Zero-wait fetch:** `pc` = 0x05, `fetch_enable` pulse at cycle 0, `imem_ack` = 1 with `imem_rdata` = 0x1234 in cycle 1 → `imem_addr` = 0x05 in cycle 1; `instruction_ready` = 1 for one cycle in cycle 2; `instr` = 0x1234; `opcode` = 0x1.
- **Wait states plus PC change:** ack delayed to cycle 4; `pc_load` = 1 with 0xA0 in cycle 2 → `imem_addr` stays 0x05 through cycle 4; `pc` = 0xA0 from cycle 3; `instruction_ready` in cycle 5.
- **Timeout:** TIMEOUT = 15, never ack → `imem_req` high in cycles 1..15; in cycle 16: `instruction_ready` = 1, `opcode` = 0xF, `fetch_error` = 1. A later `pc_load` clears `fetch_error`.
- **PC arithmetic:** `pc` = 0xFF with `pc_enable` = 1 → `pc` = 0x00. With `pc_load` = 1 (value 0x10) and `pc_enable` = 1 in the same cycle → `pc` = 0x10.
- **Closed loop with control unit:** program NOP at 0x00, ADD at 0x01, HALT at 0x02 → three fetches at addresses 0, 1, 2; `pc` = 0x02 when halted; no `imem_req` after the HALT fetch.
